// File: rtl/fft_frame_serializer_pkg.sv
// Shared FFT types: complex sample, frame container,
// default frame length and serializer state encoding.
package fft_frame_serializer_pkg;

  localparam int FFT_N = 8;
  localparam int CW    = 16;

  typedef struct packed {
    logic signed [CW-1:0] re;
    logic signed [CW-1:0] im;
  } complex_product_t;

  typedef complex_product_t fft_frame_t [FFT_N-1:0];

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } ser_state_e;

endpackage

// File: rtl/fft_frame_bank.sv
// One N-entry frame register bank with a full flag and
// a dual read port returning butterfly pair (k, k+N/2).
module fft_frame_bank
  import fft_frame_serializer_pkg::*;
#(
  parameter int N = FFT_N,
  localparam int NH = N / 2,
  localparam int KW = $clog2(NH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic                     clr,
  input  complex_product_t [N-1:0] wr_data,
  input  logic [KW-1:0]            rd_idx,
  output logic                     full,
  output complex_product_t         rd_a,
  output complex_product_t         rd_b
);

  complex_product_t [N-1:0] mem_q, mem_d;
  logic                     full_q, full_d;
  logic [KW:0]              idx_a, idx_b;

  always_comb begin
    mem_d  = mem_q;
    full_d = full_q;
    if (clr) full_d = 1'b0;
    if (wr_en) begin
      mem_d  = wr_data;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q  <= '0;
      full_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      full_q <= full_d;
    end
  end

  // N is a power of two, so k+N/2 is k with the top index bit set
  assign idx_a = {1'b0, rd_idx};
  assign idx_b = {1'b1, rd_idx};
  assign rd_a  = mem_q[idx_a];
  assign rd_b  = mem_q[idx_b];
  assign full  = full_q;

endmodule

// File: rtl/fft_frame_serializer.sv
// Ping-pong frame capture feeding the SDF FFT one
// butterfly pair per cycle, in unbroken N/2-pair runs.
module fft_frame_serializer
  import fft_frame_serializer_pkg::*;
#(
  parameter int N = FFT_N
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  complex_product_t [N-1:0] frame_in,
  output complex_product_t         data_0,
  output complex_product_t         data_1,
  output logic                     out_valid,
  output logic                     frame_start,
  output logic                     frame_last,
  output logic                     busy
);

  localparam int N_HALF = N / 2;
  localparam int KW     = $clog2(N_HALF);
  localparam logic [KW-1:0] K_LAST = KW'(N_HALF - 1);

  ser_state_e       state_q, state_d;
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [KW-1:0]    k_q, k_d;
  logic             flush_pend_q, flush_pend_d;
  complex_product_t data_0_q, data_0_d;
  complex_product_t data_1_q, data_1_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_last_q, frame_last_d;
  logic             busy_q, busy_d;

  logic [1:0]             full, set, clr, full_nxt;
  complex_product_t [1:0] rd_a, rd_b;
  logic                   capture;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank #(.N(N)) u_bank (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (set[b]),
      .clr     (clr[b]),
      .wr_data (frame_in),
      .rd_idx  (k_q),
      .full    (full[b]),
      .rd_a    (rd_a[b]),
      .rd_b    (rd_b[b])
    );
  end

  assign in_ready = !full[wr_sel_q] && !flush_pend_q;

  always_comb begin
    state_d       = state_q;
    wr_sel_d      = wr_sel_q;
    rd_sel_d      = rd_sel_q;
    k_d           = k_q;
    flush_pend_d  = flush_pend_q;
    data_0_d      = '0;
    data_1_d      = '0;
    out_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_last_d  = 1'b0;
    set           = '0;
    clr           = '0;
    // flush beats a simultaneous offer
    capture = in_valid && in_ready && !flush;
    if (capture) begin
      set[wr_sel_q] = 1'b1;
      wr_sel_d      = !wr_sel_q;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (flush) begin
          clr      = 2'b11;
          wr_sel_d = 1'b0;
          rd_sel_d = 1'b0;
        end else if (full[rd_sel_q]) begin
          out_valid_d   = 1'b1;
          data_0_d      = rd_a[rd_sel_q];
          data_1_d      = rd_b[rd_sel_q];
          frame_start_d = 1'b1;
          k_d           = KW'(1);
          state_d       = ST_STREAM;
        end
      end
      ST_STREAM: begin
        out_valid_d   = 1'b1;
        data_0_d      = rd_a[rd_sel_q];
        data_1_d      = rd_b[rd_sel_q];
        frame_start_d = (k_q == '0);
        frame_last_d  = (k_q == K_LAST);
        if (flush) flush_pend_d = 1'b1;
        if (k_q == K_LAST) begin
          k_d           = '0;
          clr[rd_sel_q] = 1'b1;
          rd_sel_d      = !rd_sel_q;
          // a flush only takes effect on a frame boundary
          if (flush_pend_q || flush) begin
            clr          = 2'b11;
            wr_sel_d     = 1'b0;
            rd_sel_d     = 1'b0;
            flush_pend_d = 1'b0;
            state_d      = ST_IDLE;
          end else if (!full[!rd_sel_q]) begin
            state_d = ST_IDLE;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    full_nxt = set | (full & ~clr);
    busy_d   = (state_d == ST_STREAM) || out_valid_d || (|full_nxt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      wr_sel_q      <= 1'b0;
      rd_sel_q      <= 1'b0;
      k_q           <= '0;
      flush_pend_q  <= 1'b0;
      data_0_q      <= '0;
      data_1_q      <= '0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_last_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_sel_q      <= wr_sel_d;
      rd_sel_q      <= rd_sel_d;
      k_q           <= k_d;
      flush_pend_q  <= flush_pend_d;
      data_0_q      <= data_0_d;
      data_1_q      <= data_1_d;
      out_valid_q   <= out_valid_d;
      frame_start_q <= frame_start_d;
      frame_last_q  <= frame_last_d;
      busy_q        <= busy_d;
    end
  end

  assign data_0      = data_0_q;
  assign data_1      = data_1_q;
  assign out_valid   = out_valid_q;
  assign frame_start = frame_start_q;
  assign frame_last  = frame_last_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Bench for fft_frame_serializer: directed scenarios plus
// random frame streams against a frame-queue reference model.
module tb_fft_frame_serializer;
  import fft_frame_serializer_pkg::*;

  localparam int N  = FFT_N;
  localparam int NH = N / 2;

  typedef complex_product_t [N-1:0] pframe_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  pframe_t          frame_in;
  complex_product_t data_0;
  complex_product_t data_1;
  logic             out_valid;
  logic             frame_start;
  logic             frame_last;
  logic             busy;

  int vecs = 0;
  int errs = 0;

  fft_frame_serializer #(.N(N)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .frame_in    (frame_in),
    .data_0      (data_0),
    .data_1      (data_1),
    .out_valid   (out_valid),
    .frame_start (frame_start),
    .frame_last  (frame_last),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic pframe_t rand_frame();
    pframe_t f;
    for (int i = 0; i < N; i++) begin
      f[i].re = 16'($urandom);
      f[i].im = 16'($urandom);
    end
    return f;
  endfunction

  task automatic test_reset();
    reset_n  = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    frame_in = '0;
    tick();
    tick();
    vecs++;
    if (out_valid !== 1'b0 || frame_start !== 1'b0 || frame_last !== 1'b0 ||
        busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_flags: got v%b s%b l%b b%b want all 0",
               out_valid, frame_start, frame_last, busy);
    end
    vecs++;
    if (data_0 !== '0 || data_1 !== '0 || in_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_data: got d0=%h d1=%h rdy=%b want 0 0 1",
               data_0, data_1, in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    vecs++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL post_reset: got v%b rdy%b b%b want 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_single();
    pframe_t     f;
    logic [15:0] e0, e1;
    for (int i = 0; i < N; i++) begin
      f[i].re = 16'(i + 1);
      f[i].im = '0;
    end
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL single_ready: got %b want 1", in_ready);
    end
    in_valid = 1'b1;
    frame_in = f;
    tick();
    in_valid = 1'b0;
    frame_in = rand_frame();
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL single_lat1: got out_valid=%b want 0", out_valid);
    end
    for (int k = 0; k < NH; k++) begin
      tick();
      e0 = 16'(k + 1);
      e1 = 16'(k + 1 + NH);
      vecs++;
      if (out_valid !== 1'b1 || data_0.re !== e0 || data_1.re !== e1 ||
          data_0.im !== '0 || data_1.im !== '0) begin
        errs++;
        $display("FAIL single_pair%0d: got v=%b (%0d,%0d) want v=1 (%0d,%0d)",
                 k, out_valid, data_0.re, data_1.re, e0, e1);
      end
      vecs++;
      if (frame_start !== 1'(k == 0) || frame_last !== 1'(k == NH - 1)) begin
        errs++;
        $display("FAIL single_marks%0d: got s%b l%b want s%b l%b",
                 k, frame_start, frame_last, k == 0, k == NH - 1);
      end
    end
    tick();
    vecs++;
    if (out_valid !== 1'b0 || data_0 !== '0 || data_1 !== '0 ||
        frame_start !== 1'b0 || frame_last !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL single_tail: got v%b d0=%h d1=%h s%b l%b b%b want all 0",
               out_valid, data_0, data_1, frame_start, frame_last, busy);
    end
  endtask

  // Reference model: a queue of captured frames and a count of
  // occupied banks; a frame frees its bank when its last pair shows.
  task automatic run_stream(input int nframes, input int gap_pct,
                            input bit gapless, input string tag);
    pframe_t          pend[$];
    pframe_t          sb[$];
    int               k_exp, occ, cyc, first_hs, first_ov, nvalid;
    bit               hs, busy_exp;
    complex_product_t e0, e1;
    k_exp    = 0;
    occ      = 0;
    cyc      = 0;
    first_hs = -1;
    first_ov = -1;
    nvalid   = 0;
    flush    = 1'b0;
    for (int f = 0; f < nframes; f++) pend.push_back(rand_frame());
    while ((pend.size() > 0 || sb.size() > 0) && cyc < nframes * N * 4 + 50) begin
      busy_exp = (occ > 0);
      vecs++;
      if (busy !== busy_exp) begin
        errs++;
        $display("FAIL %s busy cyc%0d: got %b want %b", tag, cyc, busy, busy_exp);
      end
      if (out_valid === 1'b1) begin
        if (first_ov < 0) first_ov = cyc;
        nvalid++;
        vecs++;
        if (sb.size() == 0) begin
          errs++;
          $display("FAIL %s spurious cyc%0d: got out_valid 1 want 0", tag, cyc);
        end else begin
          e0 = sb[0][k_exp];
          e1 = sb[0][k_exp + NH];
          if (data_0 !== e0 || data_1 !== e1) begin
            errs++;
            $display("FAIL %s data cyc%0d k%0d: got %h %h want %h %h",
                     tag, cyc, k_exp, data_0, data_1, e0, e1);
          end
          vecs++;
          if (frame_start !== 1'(k_exp == 0) ||
              frame_last !== 1'(k_exp == NH - 1)) begin
            errs++;
            $display("FAIL %s marks cyc%0d k%0d: got s%b l%b want s%b l%b",
                     tag, cyc, k_exp, frame_start, frame_last,
                     k_exp == 0, k_exp == NH - 1);
          end
          k_exp++;
          if (k_exp == NH) begin
            k_exp = 0;
            void'(sb.pop_front());
            occ--;
          end
        end
      end else begin
        vecs++;
        if (data_0 !== '0 || data_1 !== '0 || frame_start !== 1'b0 ||
            frame_last !== 1'b0 || k_exp != 0) begin
          errs++;
          $display("FAIL %s idle cyc%0d: got d0=%h d1=%h s%b l%b at k%0d want 0 at k0",
                   tag, cyc, data_0, data_1, frame_start, frame_last, k_exp);
        end
        if (gapless && nvalid > 0) begin
          vecs++;
          if (sb.size() > 0) begin
            errs++;
            $display("FAIL %s bubble cyc%0d: got out_valid 0 want 1", tag, cyc);
          end
        end
      end
      vecs++;
      if (in_ready !== 1'(occ < 2)) begin
        errs++;
        $display("FAIL %s in_ready cyc%0d: got %b want %b", tag, cyc, in_ready, occ < 2);
      end
      if (pend.size() > 0 && $urandom_range(99) >= gap_pct) begin
        in_valid = 1'b1;
        frame_in = pend[0];
      end else begin
        in_valid = 1'b0;
        frame_in = rand_frame();
      end
      hs = in_valid && (occ < 2);
      if (hs && first_hs < 0) first_hs = cyc;
      tick();
      cyc++;
      if (hs) begin
        sb.push_back(pend.pop_front());
        occ++;
      end
    end
    in_valid = 1'b0;
    vecs++;
    if (pend.size() != 0 || sb.size() != 0) begin
      errs++;
      $display("FAIL %s timeout: got %0d/%0d frames left want 0",
               tag, pend.size(), sb.size());
    end
    vecs++;
    if (first_ov != first_hs + 2) begin
      errs++;
      $display("FAIL %s latency: got first out_valid cyc%0d want cyc%0d",
               tag, first_ov, first_hs + 2);
    end
  endtask

  task automatic test_flush();
    pframe_t fa, fb;
    fa = rand_frame();
    fb = rand_frame();
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL flush_rdyA: got %b want 1", in_ready);
    end
    in_valid = 1'b1;
    frame_in = fa;
    tick();
    frame_in = fb;
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL flush_rdyB: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    frame_in = rand_frame();
    for (int k = 0; k < NH; k++) begin
      vecs++;
      if (out_valid !== 1'b1 || data_0 !== fa[k] || data_1 !== fa[k + NH]) begin
        errs++;
        $display("FAIL flush_pairA%0d: got v%b %h %h want v1 %h %h",
                 k, out_valid, data_0, data_1, fa[k], fa[k + NH]);
      end
      vecs++;
      if (in_ready !== 1'(k == NH - 1)) begin
        errs++;
        $display("FAIL flush_rdy%0d: got %b want %b", k, in_ready, k == NH - 1);
      end
      flush = (k == 1);
      tick();
      flush = 1'b0;
    end
    for (int c = 0; c < 6; c++) begin
      vecs++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
        errs++;
        $display("FAIL flush_drop%0d: got v%b b%b rdy%b want 0 0 1",
                 c, out_valid, busy, in_ready);
      end
      tick();
    end
    in_valid = 1'b1;
    flush    = 1'b1;
    frame_in = rand_frame();
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    for (int c = 0; c < 5; c++) begin
      vecs++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
        errs++;
        $display("FAIL flush_vs_valid%0d: got v%b b%b rdy%b want 0 0 1",
                 c, out_valid, busy, in_ready);
      end
      tick();
    end
    run_stream(2, 0, 1'b1, "post_flush");
  endtask

  task automatic test_reset_midframe();
    pframe_t f;
    f = rand_frame();
    in_valid = 1'b1;
    frame_in = f;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    vecs++;
    if (out_valid !== 1'b1 || data_0 !== f[2]) begin
      errs++;
      $display("FAIL rst_k2: got v%b %h want v1 %h", out_valid, data_0, f[2]);
    end
    reset_n = 1'b0;
    #1;
    vecs++;
    if (out_valid !== 1'b0 || data_0 !== '0 || data_1 !== '0 ||
        frame_start !== 1'b0 || frame_last !== 1'b0 || busy !== 1'b0 ||
        in_ready !== 1'b1) begin
      errs++;
      $display("FAIL rst_abort: got v%b d0=%h d1=%h s%b l%b b%b rdy%b want 0s rdy1",
               out_valid, data_0, data_1, frame_start, frame_last, busy, in_ready);
    end
    tick();
    tick();
    #2;
    reset_n = 1'b1;
    tick();
    run_stream(1, 0, 1'b0, "post_reset");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    run_stream(2, 0, 1'b1, "back_to_back");
    run_stream(3, 0, 1'b1, "three_frames");
    test_flush();
    test_reset_midframe();
    run_stream(300, 35, 1'b0, "random_gaps");
    run_stream(64, 0, 1'b1, "continuous");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
